// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: sequences IF/ID/EX/MEM/WB and drives
// datapath strobes and opcode-decoded mux selects.
module multicycle_control_unit #(
    parameter int OPW = 6,
    parameter int SW  = 3
) (
    input  logic           clk,
    input  logic           Reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           PCWre,
    output logic           IRWre,
    output logic           InsMemRW,
    output logic           RegWre,
    output logic           DataMemRW,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic           ALUM2Reg,
    output logic           WrRegData,
    output logic           ExtSel,
    output logic [1:0]     RegOut,
    output logic [1:0]     PCSrc,
    output logic [2:0]     ALUOp,
    output logic [SW-1:0]  state
);

    localparam logic [SW-1:0] S_IF  = 3'b000;
    localparam logic [SW-1:0] S_ID  = 3'b001;
    localparam logic [SW-1:0] S_EXA = 3'b110;
    localparam logic [SW-1:0] S_WBA = 3'b111;
    localparam logic [SW-1:0] S_EXB = 3'b101;
    localparam logic [SW-1:0] S_EXM = 3'b010;
    localparam logic [SW-1:0] S_MEM = 3'b011;
    localparam logic [SW-1:0] S_WBL = 3'b100;

    localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
    localparam logic [OPW-1:0] OP_OR   = 6'b010000;
    localparam logic [OPW-1:0] OP_AND  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
    localparam logic [OPW-1:0] OP_SLL  = 6'b011000;
    localparam logic [OPW-1:0] OP_SLT  = 6'b100110;
    localparam logic [OPW-1:0] OP_SW   = 6'b110000;
    localparam logic [OPW-1:0] OP_LW   = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OPW-1:0] OP_J    = 6'b111000;
    localparam logic [OPW-1:0] OP_JR   = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL  = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT = 6'b111111;

    logic [SW-1:0] state_q, state_d;
    logic is_add, is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt;
    logic is_sw, is_lw, is_beq, is_j, is_jr, is_jal, is_halt;
    logic is_alu, is_rtype, is_nop, ends_in_id;

    assign is_add  = (opcode == OP_ADD);
    assign is_sub  = (opcode == OP_SUB);
    assign is_addi = (opcode == OP_ADDI);
    assign is_or   = (opcode == OP_OR);
    assign is_and  = (opcode == OP_AND);
    assign is_ori  = (opcode == OP_ORI);
    assign is_sll  = (opcode == OP_SLL);
    assign is_slt  = (opcode == OP_SLT);
    assign is_sw   = (opcode == OP_SW);
    assign is_lw   = (opcode == OP_LW);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_j    = (opcode == OP_J);
    assign is_jr   = (opcode == OP_JR);
    assign is_jal  = (opcode == OP_JAL);
    assign is_halt = (opcode == OP_HALT);

    assign is_rtype = is_add | is_sub | is_or | is_and | is_sll | is_slt;
    assign is_alu   = is_rtype | is_addi | is_ori;
    assign is_nop   = ~(is_alu | is_sw | is_lw | is_beq |
                        is_j | is_jr | is_jal | is_halt);
    assign ends_in_id = is_j | is_jr | is_jal | is_nop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID: begin
                if (is_halt)
                    state_d = S_ID;
                else if (ends_in_id)
                    state_d = S_IF;
                else if (is_beq)
                    state_d = S_EXB;
                else if (is_sw || is_lw)
                    state_d = S_EXM;
                else
                    state_d = S_EXA;
            end
            S_EXA: state_d = S_WBA;
            S_WBA: state_d = S_IF;
            S_EXB: state_d = S_IF;
            S_EXM: state_d = S_MEM;
            S_MEM: state_d = is_lw ? S_WBL : S_IF;
            S_WBL: state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)
            state_q <= S_IF;
        else
            state_q <= state_d;
    end

    assign state = state_q;

    // Strobes are squashed while reset is held even though state reads IF
    assign IRWre     = Reset & (state_q == S_IF);
    assign InsMemRW  = Reset & (state_q == S_IF);
    assign PCWre     = Reset & (((state_q == S_ID) & ends_in_id) |
                                (state_q == S_EXB) |
                                (state_q == S_WBA) |
                                (state_q == S_WBL) |
                                ((state_q == S_MEM) & is_sw));
    assign RegWre    = Reset & ((state_q == S_WBA) |
                                (state_q == S_WBL) |
                                ((state_q == S_ID) & is_jal));
    assign DataMemRW = Reset & (state_q == S_MEM) & is_sw;

    assign ALUSrcA   = is_sll;
    assign ALUSrcB   = is_addi | is_ori | is_sw | is_lw;
    assign ExtSel    = ~is_ori;
    assign ALUM2Reg  = is_lw;
    assign WrRegData = ~is_jal;

    always_comb begin
        RegOut = 2'b00;
        if (is_addi || is_ori || is_lw)
            RegOut = 2'b01;
        else if (is_rtype)
            RegOut = 2'b10;
    end

    always_comb begin
        PCSrc = 2'b00;
        if (is_j || is_jal)
            PCSrc = 2'b11;
        else if (is_jr)
            PCSrc = 2'b10;
        else if (is_beq && zero && (state_q == S_EXB))
            PCSrc = 2'b01;
    end

    always_comb begin
        ALUOp = 3'b000;
        if (is_sub || is_beq)
            ALUOp = 3'b001;
        else if (is_sll)
            ALUOp = 3'b010;
        else if (is_or || is_ori)
            ALUOp = 3'b011;
        else if (is_and)
            ALUOp = 3'b100;
        else if (is_slt)
            ALUOp = 3'b101;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit: walks each
// instruction class state by state against hand-computed outputs.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWre, IRWre, InsMemRW, RegWre, DataMemRW;
    logic       ALUSrcA, ALUSrcB, ALUM2Reg, WrRegData, ExtSel;
    logic [1:0] RegOut, PCSrc;
    logic [2:0] ALUOp;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    multicycle_control_unit #(.OPW(6), .SW(3)) dut (
        .clk(clk), .Reset(Reset), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .RegWre(RegWre), .DataMemRW(DataMemRW),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg),
        .WrRegData(WrRegData), .ExtSel(ExtSel),
        .RegOut(RegOut), .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe vector: {PCWre, IRWre, InsMemRW, RegWre, DataMemRW}
    function automatic logic [7:0] obs();
        return {state, PCWre, IRWre, InsMemRW, RegWre, DataMemRW};
    endfunction

    // Check the current cycle, then move to the next falling edge
    task automatic cyc(input string tag, input logic [2:0] st,
                       input logic [4:0] s);
        chk(tag, 32'(obs()), 32'({st, s}));
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [4:0] S_IFV  = 5'b01100;
    localparam logic [4:0] S_NONE = 5'b00000;

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        Reset  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;
        #1;
        chk("rst_async", 32'(obs()), 32'({3'b000, S_NONE}));
        @(negedge clk);
        @(negedge clk);
        chk("rst_held", 32'(obs()), 32'({3'b000, S_NONE}));
        chk("rst_regout", 32'(RegOut), 32'd2);
        Reset = 1'b1;
        #1;

        // add, interrupted in WBA
        cyc("add0_if",  3'b000, S_IFV);
        cyc("add0_id",  3'b001, S_NONE);
        cyc("add0_exa", 3'b110, S_NONE);
        chk("add0_wba", 32'(obs()), 32'({3'b111, 5'b10010}));
        Reset = 1'b0;
        #1;
        chk("midrst", 32'(obs()), 32'({3'b000, S_NONE}));
        @(negedge clk);
        chk("midrst_hold", 32'(obs()), 32'({3'b000, S_NONE}));
        Reset = 1'b1;
        #1;
        cyc("add_if",  3'b000, S_IFV);
        cyc("add_id",  3'b001, S_NONE);
        cyc("add_exa", 3'b110, S_NONE);
        chk("add_regout", 32'(RegOut), 32'd2);
        chk("add_aluop", 32'(ALUOp), 32'd0);
        cyc("add_wba", 3'b111, 5'b10010);

        // lw
        opcode = 6'b110001;
        cyc("lw_if",  3'b000, S_IFV);
        chk("lw_sel", 32'({ALUM2Reg, ALUSrcB, ExtSel, RegOut, ALUOp}),
            32'({1'b1, 1'b1, 1'b1, 2'b01, 3'b000}));
        cyc("lw_id",  3'b001, S_NONE);
        cyc("lw_exm", 3'b010, S_NONE);
        cyc("lw_mem", 3'b011, S_NONE);
        cyc("lw_wbl", 3'b100, 5'b10010);

        // sw
        opcode = 6'b110000;
        cyc("sw_if",  3'b000, S_IFV);
        cyc("sw_id",  3'b001, S_NONE);
        cyc("sw_exm", 3'b010, S_NONE);
        cyc("sw_mem", 3'b011, 5'b10001);
        chk("sw_back_if", 32'(state), 32'd0);

        // beq taken; zero glitches in ID must not matter
        opcode = 6'b110100;
        cyc("beq1_if", 3'b000, S_IFV);
        zero = 1'b1;
        cyc("beq1_id", 3'b001, S_NONE);
        chk("beq1_pcsrc", 32'(PCSrc), 32'd1);
        chk("beq1_aluop", 32'(ALUOp), 32'd1);
        cyc("beq1_exb", 3'b101, 5'b10000);

        // beq not taken
        zero = 1'b0;
        cyc("beq0_if", 3'b000, S_IFV);
        zero = 1'b1;
        cyc("beq0_id", 3'b001, S_NONE);
        zero = 1'b0;
        #1;
        chk("beq0_pcsrc", 32'(PCSrc), 32'd0);
        cyc("beq0_exb", 3'b101, 5'b10000);

        // ori selects
        opcode = 6'b010010;
        #1;
        chk("ori_sel", 32'({ExtSel, ALUSrcB, RegOut, ALUOp}),
            32'({1'b0, 1'b1, 2'b01, 3'b011}));
        opcode = 6'b011000;
        #1;
        chk("sll_sel", 32'({ALUSrcA, RegOut, ALUOp}),
            32'({1'b1, 2'b10, 3'b010}));

        // jal
        opcode = 6'b111010;
        cyc("jal_if", 3'b000, S_IFV);
        chk("jal_sel", 32'({PCSrc, RegOut, WrRegData}),
            32'({2'b11, 2'b00, 1'b0}));
        cyc("jal_id", 3'b001, 5'b10010);

        // jr
        opcode = 6'b111001;
        cyc("jr_if", 3'b000, S_IFV);
        chk("jr_pcsrc", 32'(PCSrc), 32'd2);
        cyc("jr_id", 3'b001, 5'b10000);

        // halt
        opcode = 6'b111111;
        cyc("halt_if", 3'b000, S_IFV);
        for (int i = 0; i < 20; i++)
            cyc($sformatf("halt_%0d", i), 3'b001, S_NONE);

        // undefined opcode after reset
        Reset = 1'b0;
        #1;
        chk("halt_rst", 32'(obs()), 32'({3'b000, S_NONE}));
        @(negedge clk);
        Reset  = 1'b1;
        opcode = 6'b101010;
        #1;
        cyc("nop_if", 3'b000, S_IFV);
        chk("nop_pcsrc", 32'(PCSrc), 32'd0);
        cyc("nop_id", 3'b001, 5'b10000);
        cyc("nop_back_if", 3'b000, S_IFV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Control FSM for the multicycle CPU. It consumes the opcode field held in the instruction register and the ALU status flags, sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath write-enable and mux select. It also produces the IR load strobe (`IRWre`) that captures the fetched word.

## Interface
Parameters:
- `OPW`, 6: opcode width.
- `SW`, 3: state register width.

Ports:
- `clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction bits [31:26] from the IR output.
- `zero`  in  1  ALU result == 0, valid combinationally in the execute cycle.
- `PCWre`  out  1  PC load enable.
- `IRWre`  out  1  IR load enable.
- `InsMemRW`  out  1  instruction memory read strobe.
- `RegWre`  out  1  register file write enable.
- `DataMemRW`  out  1  data memory write (1) / read (0).
- `ALUSrcA`  out  1  1 = shamt, 0 = rs.
- `ALUSrcB`  out  1  1 = extended immediate, 0 = rt.
- `ALUM2Reg`  out  1  1 = write-back from data memory.
- `WrRegData`  out  1  0 = PC+4 (jal), 1 = ALU/memory.
- `ExtSel`  out  1  1 = sign-extend, 0 = zero-extend.
- `RegOut`  out  2  destination register: 00 = $31, 01 = rt, 10 = rd.
- `PCSrc`  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = jump target.
- `ALUOp`  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 signed slt.
- `state`  out  3  current state, for debug.

## Operation
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - sll 011000, slt 100110
  - sw 110000, lw 110001, beq 110100
  - j 111000, jr 111001, jal 111010, halt 111111
  - Any other opcode is a NOP.
- State encodings: IF 000, ID 001, EXA 110, WBA 111, EXB 101, EXM 010, MEM 011, WBL 100.
- Transitions:
  - IF→ID.
  - ID→IF for j, jr, jal and NOP.
  - ID→ID for halt (holds until reset).
  - ID→EXB for beq.
  - ID→EXM for sw and lw.
  - ID→EXA for the remaining ALU ops.
  - EXA→WBA→IF.
  - EXB→IF.
  - EXM→MEM.
  - MEM→IF for sw; MEM→WBL→IF for lw.
- State-gated strobes (0 in every other state):
  - `IRWre` and `InsMemRW`: 1 only in IF.
  - `PCWre`: 1 only in the final state of an instruction:
    - ID for j, jr, jal and NOP.
    - EXB, WBA, WBL.
    - MEM for sw.
    - Never 1 for halt.
  - `RegWre`: 1 in WBA, in WBL, and in ID for jal.
  - `DataMemRW`: 1 only in MEM for sw.
- Opcode-decoded selects (combinational on `opcode`, stable for the whole instruction because the IR holds):
  - `ALUSrcB` = 1 for addi, ori, sw, lw.
  - `ALUSrcA` = 1 for sll.
  - `ExtSel` = 0 for ori, 1 otherwise.
  - `ALUM2Reg` = 1 for lw.
  - `WrRegData` = 0 for jal.
  - `RegOut`: 00 for jal; 01 for addi, ori, lw; 10 for add, sub, or, and, sll, slt.
  - `ALUOp`: sub for beq; add for sw and lw.
  - `PCSrc`:
    - 11 for j and jal; 10 for jr.
    - 01 for beq when `zero`=1; 00 for beq when `zero`=0.
    - 00 otherwise.
  - Don't-care selects drive 0.

## Timing
- Reset asserted (`Reset`=0): `state` goes to IF immediately. All strobes (`PCWre`, `IRWre`, `InsMemRW`, `RegWre`, `DataMemRW`) are forced to 0 while reset is held. Decoded selects follow `opcode`.
- Reset mid-instruction: the instruction is abandoned and no further strobes are issued. On the first rising edge after release, the block is in IF with `IRWre`=1.
- Cycles per instruction:
  - j, jr, jal, NOP: 2.
  - beq: 3.
  - ALU ops and sw: 4.
  - lw: 5.
- The PC update and the IR load never coincide. `PCWre` is asserted on the edge that enters IF, and the IR loads at the end of IF.
- `zero` is sampled only in EXB. A glitch on `zero` in any other state has no effect.
- halt: stays in ID indefinitely with all strobes 0. It is left only through reset.

## Test plan
- Reset low mid-WBA, release, hold `opcode`=000000 → `state`=000 immediately, `RegWre`=0. After release the sequence is IF, ID, EXA, WBA with `RegWre`=1 only in WBA and `RegOut`=10.
- lw (110001) → states 000, 001, 010, 011, 100, 000. `DataMemRW`=0 throughout. `ALUM2Reg`=1, `ALUSrcB`=1. `RegWre`=1 and `PCWre`=1 only in WBL.
- sw (110000) → `DataMemRW`=1 and `PCWre`=1 only in MEM. `RegWre` never 1. 4 cycles total.
- beq (110100) with `zero`=1, then with `zero`=0 → in EXB, `PCSrc`=01 and 00 respectively, `PCWre`=1, `ALUOp`=001. Returns to IF.
- jal (111010) → in ID, `PCWre`=1, `RegWre`=1, `PCSrc`=11, `RegOut`=00, `WrRegData`=0. 2 cycles.
- halt (111111), then an undefined opcode 101010 after reset → halt: `state` stays 001 for 20 cycles, `PCWre`=0. Undefined opcode: ID→IF with `PCWre`=1, `PCSrc`=00.
